// File: rtl/inst_buffer_pkg.sv
// Shared definitions for the instruction buffer between fetch and dispatch.
// Holds the superscalar width, buffer geometry, the fetch/dispatch packet
// and a small helper used when sizing the retired prefix.
package inst_buffer_pkg;

   localparam int unsigned SUPERSCALAR_WAYS      = 3;
   localparam int unsigned SUPERSCALAR_WAYS_BITS = 2;
   localparam int unsigned WAYS                  = SUPERSCALAR_WAYS;
   // Wide enough to hold 0..WAYS (a per-cycle instruction count).
   localparam int unsigned WAY_CNT_BITS          = $clog2(WAYS + 1);

   localparam int unsigned IB_DEPTH              = 8;
   localparam int unsigned IB_PTR_BITS           = $clog2(IB_DEPTH);
   localparam int unsigned IB_CNT_BITS           = IB_PTR_BITS + 1;

   typedef struct packed {
      logic        valid;
      logic [31:0] inst;
      logic [31:0] PC;
      logic [31:0] NPC;
   } FETCH_DISPATCH_PACKET;

   typedef struct packed {
      logic                   stall;
      logic [IB_CNT_BITS-1:0] count;
   } IB_FETCH_PACKET;

   function automatic logic [WAY_CNT_BITS-1:0] way_min(input logic [WAY_CNT_BITS-1:0] a,
                                                       input logic [WAY_CNT_BITS-1:0] b);
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/inst_buffer_if.sv
// Fetch/dispatch-facing signal bundle of the instruction buffer.
//   fetch_ib_in              fetched packets, one per way
//   dispatch_stall_en        dispatch stalled structurally this cycle
//   dispatch_first_stall_idx first way dispatch did not accept
//   ib_dispatch_out          oldest entries, way 0 oldest
//   ib_stall                 fewer than WAYS free slots
//   ib_count                 occupied entries (registered)
// master: the fetch/dispatch side.  slave: the buffer.
interface inst_buffer_if;
   import inst_buffer_pkg::*;

   FETCH_DISPATCH_PACKET [WAYS-1:0]      fetch_ib_in;
   logic                                 dispatch_stall_en;
   logic [SUPERSCALAR_WAYS_BITS-1:0]     dispatch_first_stall_idx;
   FETCH_DISPATCH_PACKET [WAYS-1:0]      ib_dispatch_out;
   logic                                 ib_stall;
   logic [IB_CNT_BITS-1:0]               ib_count;

   modport master (
      output fetch_ib_in, dispatch_stall_en, dispatch_first_stall_idx,
      input  ib_dispatch_out, ib_stall, ib_count
   );

   modport slave (
      input  fetch_ib_in, dispatch_stall_en, dispatch_first_stall_idx,
      output ib_dispatch_out, ib_stall, ib_count
   );

endinterface

// File: rtl/inst_buffer_compact.sv
// Valid-bit compaction for a fetch group.
//   valid_i   per-way valid bits
//   offset_o  per-way write offset: number of valid ways below this one
//   pushed_o  popcount of valid_i
// Purely combinational; reusable wherever a sparse group must be packed.
module inst_buffer_compact
   import inst_buffer_pkg::*;
(
   input  logic [WAYS-1:0]                    valid_i,
   output logic [WAYS-1:0][WAY_CNT_BITS-1:0]  offset_o,
   output logic [WAY_CNT_BITS-1:0]            pushed_o
);

   always_comb begin
      logic [WAY_CNT_BITS-1:0] run;
      run      = '0;
      offset_o = '0;
      for (int w = 0; w < WAYS; w++) begin
         offset_o[w] = run;
         run         = run + WAY_CNT_BITS'(valid_i[w]);
      end
      pushed_o = run;
   end

endmodule

// File: rtl/inst_buffer.sv
// Circular instruction queue between fetch and dispatch.
//   clock, reset      system clock, synchronous active-high reset
//   branch_flush_en   mispredict flush, empties the buffer
//   ib_if (slave)     fetch input, dispatch stall info, dispatch window,
//                     ib_stall and ib_count
// Optional macro IB_STATS_EN adds 32-bit saturating counters
// ib_full_cycles, ib_empty_cycles and ib_flushed_insts.
module inst_buffer
   import inst_buffer_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        branch_flush_en,
   inst_buffer_if.slave ib_if
`ifdef IB_STATS_EN
   ,
   output logic [31:0] ib_full_cycles,
   output logic [31:0] ib_empty_cycles,
   output logic [31:0] ib_flushed_insts
`endif
);

   FETCH_DISPATCH_PACKET             mem_q [IB_DEPTH];
   logic [IB_PTR_BITS-1:0]           head_q, head_d;
   logic [IB_PTR_BITS-1:0]           tail_q, tail_d;
   logic [IB_CNT_BITS-1:0]           count_q, count_d;

   logic                             stall;
   logic                             push_en;
   logic [WAYS-1:0]                  fetch_valid;
   logic [WAYS-1:0][WAY_CNT_BITS-1:0] wr_offset;
   logic [WAY_CNT_BITS-1:0]          pushed;
   logic [WAY_CNT_BITS-1:0]          presented;
   logic [WAY_CNT_BITS-1:0]          popped;

   always_comb begin
      for (int w = 0; w < WAYS; w++) begin
         fetch_valid[w] = ib_if.fetch_ib_in[w].valid;
      end
   end

   inst_buffer_compact u_compact (
      .valid_i  (fetch_valid),
      .offset_o (wr_offset),
      .pushed_o (pushed)
   );

   // Free slots < WAYS, from registered count only so dispatch has no
   // combinational path to fetch.
   assign stall   = count_q > IB_CNT_BITS'(IB_DEPTH - WAYS);
   assign push_en = ~stall & ~branch_flush_en;

   always_comb begin
      presented = (count_q >= IB_CNT_BITS'(WAYS)) ? WAY_CNT_BITS'(WAYS)
                                                   : count_q[WAY_CNT_BITS-1:0];
      popped    = ib_if.dispatch_stall_en
                ? way_min(WAY_CNT_BITS'(ib_if.dispatch_first_stall_idx), presented)
                : presented;
   end

   always_comb begin
      head_d  = head_q + IB_PTR_BITS'(popped);
      tail_d  = push_en ? tail_q + IB_PTR_BITS'(pushed) : tail_q;
      count_d = count_q - IB_CNT_BITS'(popped)
              + (push_en ? IB_CNT_BITS'(pushed) : IB_CNT_BITS'(0));
      if (branch_flush_en) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // No reset on storage: stale entries are masked by count.  Popped and
   // written slots never alias because a push needs WAYS free slots.
   always_ff @(posedge clock) begin
      if (push_en) begin
         for (int w = 0; w < WAYS; w++) begin
            if (fetch_valid[w]) begin
               mem_q[tail_q + IB_PTR_BITS'(wr_offset[w])] <= ib_if.fetch_ib_in[w];
            end
         end
      end
   end

   always_comb begin
      logic [IB_PTR_BITS-1:0] rd_idx;
      rd_idx = '0;
      for (int i = 0; i < WAYS; i++) begin
         rd_idx = head_q + IB_PTR_BITS'(i);
         ib_if.ib_dispatch_out[i] = (IB_CNT_BITS'(i) < count_q) ? mem_q[rd_idx] : '0;
      end
   end

   assign ib_if.ib_stall = stall;
   assign ib_if.ib_count = count_q;

`ifdef IB_STATS_EN
   logic [31:0] full_q, full_d;
   logic [31:0] empty_q, empty_d;
   logic [31:0] flushed_q, flushed_d;

   always_comb begin
      logic [32:0] sum;
      sum       = {1'b0, flushed_q} + 33'(count_q);
      full_d    = (stall && full_q != '1) ? full_q + 32'd1 : full_q;
      empty_d   = (count_q == '0 && empty_q != '1) ? empty_q + 32'd1 : empty_q;
      flushed_d = flushed_q;
      if (branch_flush_en) begin
         flushed_d = sum[32] ? '1 : sum[31:0];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         full_q    <= '0;
         empty_q   <= '0;
         flushed_q <= '0;
      end else begin
         full_q    <= full_d;
         empty_q   <= empty_d;
         flushed_q <= flushed_d;
      end
   end

   assign ib_full_cycles   = full_q;
   assign ib_empty_cycles  = empty_q;
   assign ib_flushed_insts = flushed_q;
`endif

`ifndef SYNTHESIS
   a_count_le_depth: assert property (@(posedge clock) disable iff (reset)
      count_q <= IB_CNT_BITS'(IB_DEPTH));
   a_push_le_free: assert property (@(posedge clock) disable iff (reset)
      push_en |-> (IB_CNT_BITS'(pushed) <= IB_CNT_BITS'(IB_DEPTH) - count_q));
   a_pop_le_count: assert property (@(posedge clock) disable iff (reset)
      IB_CNT_BITS'(popped) <= count_q);
`endif

endmodule

// File: tb/tb_inst_buffer.sv
// Scoreboard bench for inst_buffer: a queue-based reference model produces
// the expected window each cycle; a monitor compares it against the DUT.
module tb_inst_buffer;
   import inst_buffer_pkg::*;

   logic clock = 1'b0;
   logic reset;
   logic branch_flush_en;

   inst_buffer_if ib_if ();

`ifdef IB_STATS_EN
   logic [31:0] full_cycles, empty_cycles, flushed_insts;
`endif

   inst_buffer dut (
      .clock           (clock),
      .reset           (reset),
      .branch_flush_en (branch_flush_en),
      .ib_if           (ib_if)
`ifdef IB_STATS_EN
      ,
      .ib_full_cycles  (full_cycles),
      .ib_empty_cycles (empty_cycles),
      .ib_flushed_insts(flushed_insts)
`endif
   );

   always #5 clock = ~clock;

   typedef struct {
      int unsigned                     count;
      logic                            stall;
      FETCH_DISPATCH_PACKET [WAYS-1:0] out;
   } exp_t;

   exp_t                 exp_q[$];
   FETCH_DISPATCH_PACKET model_q[$];
   int unsigned          n_pass  = 0;
   int unsigned          n_total = 0;
   logic [31:0]          next_pc = 32'h0;

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
      n_total++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
   endtask

   function automatic FETCH_DISPATCH_PACKET mk(input logic [31:0] pc, input logic v);
      FETCH_DISPATCH_PACKET p;
      p.valid = v;
      p.PC    = pc;
      p.NPC   = pc + 32'd4;
      p.inst  = $urandom;
      return p;
   endfunction

   // Push the expectation for the current state, drive inputs, then advance
   // the model across the coming clock edge.
   task automatic step(input FETCH_DISPATCH_PACKET [WAYS-1:0] f, input logic se,
                       input logic [1:0] idx, input logic fl, input logic rs);
      exp_t e;
      int   n, pres, pop;
      logic st;
      @(negedge clock);
      n       = model_q.size();
      st      = (int'(IB_DEPTH) - n) < int'(WAYS);
      e.count = n;
      e.stall = st;
      for (int i = 0; i < WAYS; i++) e.out[i] = (i < n) ? model_q[i] : '0;
      exp_q.push_back(e);
      ib_if.fetch_ib_in              = f;
      ib_if.dispatch_stall_en        = se;
      ib_if.dispatch_first_stall_idx = idx;
      branch_flush_en                = fl;
      reset                          = rs;
      if (rs || fl) begin
         model_q.delete();
      end else begin
         pres = (n < int'(WAYS)) ? n : int'(WAYS);
         pop  = se ? ((int'(idx) < pres) ? int'(idx) : pres) : pres;
         repeat (pop) void'(model_q.pop_front());
         if (!st) begin
            for (int w = 0; w < WAYS; w++) if (f[w].valid) model_q.push_back(f[w]);
         end
      end
   endtask

   function automatic FETCH_DISPATCH_PACKET [WAYS-1:0] grp(input logic [2:0] v);
      FETCH_DISPATCH_PACKET [WAYS-1:0] g;
      for (int w = 0; w < WAYS; w++) begin
         g[w]    = mk(next_pc, v[w]);
         next_pc = next_pc + 32'd4;
      end
      return g;
   endfunction

   // Monitor: compare every pending expectation against the live outputs.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         #1;
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("ib_count", 128'(ib_if.ib_count), 128'(e.count));
            check("ib_stall", 128'(ib_if.ib_stall), 128'(e.stall));
            for (int i = 0; i < WAYS; i++) begin
               check($sformatf("out%0d.valid", i), 128'(ib_if.ib_dispatch_out[i].valid),
                     128'(e.out[i].valid));
               if (e.out[i].valid)
                  check($sformatf("out%0d.pkt", i), 128'(ib_if.ib_dispatch_out[i]),
                        128'(e.out[i]));
            end
         end
      end
   end

   initial begin
      FETCH_DISPATCH_PACKET [WAYS-1:0] idle, f;
      idle                           = '0;
      reset                          = 1'b1;
      branch_flush_en                = 1'b0;
      ib_if.fetch_ib_in              = '0;
      ib_if.dispatch_stall_en        = 1'b0;
      ib_if.dispatch_first_stall_idx = '0;

      step(idle, 1'b0, 2'd0, 1'b0, 1'b1);          // reset state
      step(idle, 1'b1, 2'd0, 1'b0, 1'b0);
      next_pc = 32'h0;
      step(grp(3'b111), 1'b1, 2'd0, 1'b0, 1'b0);   // PC 0,4,8
      step(idle, 1'b1, 2'd1, 1'b0, 1'b0);          // pop only PC 0
      f = '0;
      f[0] = mk(32'h10, 1'b1);
      f[2] = mk(32'h18, 1'b1);
      step(f, 1'b1, 2'd0, 1'b0, 1'b0);             // sparse 3'b101
      next_pc = 32'h40;
      step(grp(3'b011), 1'b1, 2'd0, 1'b0, 1'b0);   // fill to 6
      step(grp(3'b111), 1'b1, 2'd0, 1'b0, 1'b0);   // stalled: ignored
      step(idle, 1'b0, 2'd0, 1'b0, 1'b0);          // pop 3
      step(grp(3'b110), 1'b1, 2'd0, 1'b0, 1'b0);   // to 5 entries
      step(grp(3'b111), 1'b0, 2'd0, 1'b1, 1'b0);   // flush beats push/pop
      step(idle, 1'b1, 2'd0, 1'b0, 1'b0);
      for (int c = 0; c < 20; c++) step(grp(3'b111), 1'b0, 2'd0, 1'b0, 1'b0);

      for (int c = 0; c < 600; c++) begin
         step(grp(3'($urandom)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              ($urandom_range(0, 19) == 0), ($urandom_range(0, 99) == 0));
      end
      step(idle, 1'b1, 2'd0, 1'b0, 1'b0);
      step(idle, 1'b1, 2'd0, 1'b0, 1'b0);

      repeat (3) @(negedge clock);
      #2;
      n_total++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
